event_snapshot_buffer: RTL

- Sits directly downstream of the detector top level.
- Taps the same per-sample vectorx/vectory/pressure stream the detector consumes, plus the detector's eventDetected flag.
- Keeps a circular history. On a detection it records a pre-trigger plus post-trigger window of the three channels.
- Drains that window once over a valid/ready stream to the offload or logging stage.

---
 rtl/event_snapshot_buffer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/event_snapshot_buffer.sv
// event_snapshot_buffer
// Keeps a circular history of {vectorx, vectory, pressure} samples. When the
// detector flags an event while armed, it captures PRE_LEN samples before the
// trigger and POST_LEN samples from the trigger onward. That window is then
// drained once over a valid/ready stream, with first/last word markers.
// Optional build macro: SNAPSHOT_TIMESTAMP_EN adds a 32-bit sample counter
// and a trig_stamp output holding the counter value of the trigger sample.
module event_snapshot_buffer #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 6,
  parameter int PRE_LEN    = 16,
  parameter int POST_LEN   = 32,
  parameter int HOLDOFF    = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] vectorx,
  input  logic signed [DATA_W-1:0] vectory,
  input  logic signed [DATA_W-1:0] pressure,
  input  logic                     event_detected,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3*DATA_W-1:0]      out_data,
  output logic                     out_first,
  output logic                     out_last,
  output logic                     busy,
  output logic [15:0]              dropped
`ifdef SNAPSHOT_TIMESTAMP_EN
  ,
  output logic [31:0]              trig_stamp
`endif
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int WORD_W = 3 * DATA_W;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] PRE_OFS  = DEPTH_LOG2'(PRE_LEN);
  localparam logic [DEPTH_LOG2:0]   WIN_LEN  = (DEPTH_LOG2 + 1)'(PRE_LEN + POST_LEN);
  localparam logic [DEPTH_LOG2:0]   WIN_LAST = (DEPTH_LOG2 + 1)'(PRE_LEN + POST_LEN - 1);
  localparam logic [DEPTH_LOG2:0]   IDX_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [31:0]           PRE_LAST  = 32'(PRE_LEN - 1);
  localparam logic [31:0]           POST_LAST = 32'(POST_LEN - 1);
  localparam logic [31:0]           HOLD_LAST = 32'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    S_FILL,
    S_ARMED,
    S_POST,
    S_DRAIN,
    S_HOLDOFF
  } state_t;

  state_t                  state_reg;
  logic [DEPTH_LOG2-1:0]   wp_reg;
  logic [DEPTH_LOG2-1:0]   rp_reg;
  logic [DEPTH_LOG2:0]     issued_reg;
  logic [31:0]             cnt_reg;
  logic [15:0]             dropped_reg;

  logic [WORD_W-1:0]       mem [DEPTH];
  logic [WORD_W-1:0]       rd_data_reg;
  logic                    rd_vld_reg;
  logic                    rd_first_reg;
  logic                    rd_last_reg;
  logic                    out_valid_reg;
  logic [WORD_W-1:0]       out_data_reg;
  logic                    out_first_reg;
  logic                    out_last_reg;

  logic                    wr_en;
  logic                    trigger;
  logic                    rd_move;
  logic                    issue;
  logic                    accept;

  // The history is frozen only while the window is being drained.
  assign wr_en   = sample_valid && (state_reg != S_DRAIN);
  assign trigger = sample_valid && event_detected && (state_reg == S_ARMED);
  assign accept  = out_valid_reg && out_ready;
  // The prefetched word moves to the output whenever the output slot frees up.
  assign rd_move = rd_vld_reg && (!out_valid_reg || out_ready);
  // A new read is launched only if the prefetch slot is empty or emptying.
  assign issue   = (state_reg == S_DRAIN) && (issued_reg != WIN_LEN) &&
                   (!rd_vld_reg || rd_move);

  // Sample history and sync-read port, no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wp_reg] <= {vectorx, vectory, pressure};
    end
    if (issue) begin
      rd_data_reg <= mem[rp_reg];
    end
  end

  // Capture sequencing: fill, arm, post-trigger collection, drain and holdoff.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_FILL;
      wp_reg      <= '0;
      rp_reg      <= '0;
      issued_reg  <= '0;
      cnt_reg     <= '0;
      dropped_reg <= '0;
    end else begin
      if (wr_en) begin
        wp_reg <= wp_reg + PTR_ONE;
      end
      case (state_reg)
        S_FILL: begin
          if (sample_valid) begin
            if (cnt_reg == PRE_LAST) begin
              state_reg <= S_ARMED;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 32'd1;
            end
          end
        end
        S_ARMED: begin
          if (trigger) begin
            // The trigger sample lands at wp this cycle; the window starts
            // PRE_LEN addresses earlier.
            rp_reg     <= wp_reg - PRE_OFS;
            issued_reg <= '0;
            cnt_reg    <= 32'd1;
            if (POST_LEN == 1) begin
              state_reg <= S_DRAIN;
            end else begin
              state_reg <= S_POST;
            end
          end
        end
        S_POST: begin
          if (sample_valid) begin
            cnt_reg <= cnt_reg + 32'd1;
            if (cnt_reg == POST_LAST) begin
              state_reg <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (issue) begin
            rp_reg     <= rp_reg + PTR_ONE;
            issued_reg <= issued_reg + IDX_ONE;
          end
          if (sample_valid && (dropped_reg != 16'hFFFF)) begin
            dropped_reg <= dropped_reg + 16'd1;
          end
          if (accept && out_last_reg) begin
            state_reg <= S_HOLDOFF;
            cnt_reg   <= '0;
          end
        end
        S_HOLDOFF: begin
          if (sample_valid) begin
            if (cnt_reg == HOLD_LAST) begin
              state_reg <= S_ARMED;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 32'd1;
            end
          end
        end
        default: begin
          state_reg <= S_FILL;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // Two-stage read pipeline: prefetch slot feeding a registered output slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_vld_reg    <= 1'b0;
      rd_first_reg  <= 1'b0;
      rd_last_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_first_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      if (issue) begin
        rd_vld_reg   <= 1'b1;
        rd_first_reg <= (issued_reg == '0);
        rd_last_reg  <= (issued_reg == WIN_LAST);
      end else if (rd_move) begin
        rd_vld_reg <= 1'b0;
      end
      if (rd_move) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= rd_data_reg;
        out_first_reg <= rd_first_reg;
        out_last_reg  <= rd_last_reg;
      end else if (accept) begin
        out_valid_reg <= 1'b0;
        out_first_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end
    end
  end

`ifdef SNAPSHOT_TIMESTAMP_EN
  logic [31:0] stamp_cnt_reg;
  logic [31:0] trig_stamp_reg;

  // Free-running valid-sample counter and its snapshot at the trigger sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stamp_cnt_reg  <= '0;
      trig_stamp_reg <= '0;
    end else begin
      if (sample_valid) begin
        stamp_cnt_reg <= stamp_cnt_reg + 32'd1;
      end
      if (trigger) begin
        trig_stamp_reg <= stamp_cnt_reg;
      end
    end
  end

  assign trig_stamp = trig_stamp_reg;
`endif

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_first = out_first_reg;
  assign out_last  = out_last_reg;
  assign busy      = (state_reg != S_ARMED);
  assign dropped   = dropped_reg;

endmodule
